// File: rtl/traffic_light_monitor_if.sv
// Light bus plus monitor status signals between the controller side and the monitor.
// The master modport drives the lights and the clear; the slave modport reports status.
interface traffic_light_monitor_if #(
  parameter int CW = 5
) ();
  logic [7:0]    lights;
  logic          clr;
  logic [2:0]    phase;
  logic          phase_valid;
  logic          fault;
  logic [1:0]    fault_code;
  logic [CW-1:0] dwell;

  modport master (
    output lights, clr,
    input  phase, phase_valid, fault, fault_code, dwell
  );

  modport slave (
    input  lights, clr,
    output phase, phase_valid, fault, fault_code, dwell
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Conflict/malfunction monitor for the intersection light bus: decodes phases, checks
// phase order and dwell lengths, and latches the first fault cause until cleared.
module traffic_light_monitor #(
  parameter int T_LEFT   = 5,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int CW       = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_light_monitor_if.slave  bus
);

  typedef enum logic [2:0] {
    P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, P4 = 3'd4, P5 = 3'd5, P6 = 3'd6
  } phase_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_SEQ     = 2'b10;
  localparam logic [1:0] CODE_DWELL   = 2'b11;

  localparam logic [CW-1:0] REQ_LEFT   = CW'(T_LEFT);
  localparam logic [CW-1:0] REQ_GREEN  = CW'(T_GREEN);
  localparam logic [CW-1:0] REQ_YELLOW = CW'(T_YELLOW);
  localparam logic [CW-1:0] DWELL_ONE  = CW'(1);

  phase_t        cur_reg;
  phase_t        saved_reg;
  logic          saved_vld_reg;
  logic          valid_reg;
  logic          skip_reg;
  logic [CW-1:0] dwell_reg;
  logic          fault_reg;
  logic [1:0]    code_reg;

  phase_t        d_phase;
  logic          d_legal;
  phase_t        nxt_phase;
  logic [CW-1:0] req_dwell;
  logic [CW-1:0] dwell_inc;
  logic [1:0]    cause;

  always_comb begin
    d_legal = 1'b1;
    d_phase = P0;
    case (bus.lights)
      8'h91:   d_phase = P0;
      8'h41:   d_phase = P1;
      8'h21:   d_phase = P2;
      8'h19:   d_phase = P3;
      8'h14:   d_phase = P4;
      8'h12:   d_phase = P5;
      8'h11:   d_phase = P6;
      default: d_legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt_phase = (cur_reg == P5) ? P0 : phase_t'(cur_reg + 3'd1);
    case (cur_reg)
      P0, P3:  req_dwell = REQ_LEFT;
      P1, P4:  req_dwell = REQ_GREEN;
      default: req_dwell = REQ_YELLOW;
    endcase
    dwell_inc = (dwell_reg == '1) ? dwell_reg : dwell_reg + DWELL_ONE;
  end

  // Fault cause of the current sample; branches mirror the state update below.
  always_comb begin
    cause = CODE_NONE;
    if (!d_legal) begin
      cause = CODE_ILLEGAL;
    end else if (valid_reg && d_phase != cur_reg) begin
      if (cur_reg != P6 && d_phase == nxt_phase) begin
        if (!skip_reg && dwell_reg != req_dwell)
          cause = CODE_DWELL;
      end else if (d_phase == P6) begin
        cause = CODE_NONE;
      end else if (cur_reg == P6 && (!saved_vld_reg || d_phase == saved_reg)) begin
        cause = CODE_NONE;
      end else begin
        cause = CODE_SEQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_reg       <= P0;
      saved_reg     <= P0;
      saved_vld_reg <= 1'b0;
      valid_reg     <= 1'b0;
      skip_reg      <= 1'b1;
      dwell_reg     <= '0;
      fault_reg     <= 1'b0;
      code_reg      <= CODE_NONE;
    end else begin
      if (!d_legal) begin
        valid_reg     <= 1'b0;
        skip_reg      <= 1'b1;
        dwell_reg     <= '0;
        saved_vld_reg <= 1'b0;
      end else if (!valid_reg) begin
        cur_reg       <= d_phase;
        dwell_reg     <= DWELL_ONE;
        skip_reg      <= 1'b1;
        valid_reg     <= 1'b1;
        saved_vld_reg <= 1'b0;
      end else if (d_phase == cur_reg) begin
        if (cur_reg != P6)
          dwell_reg <= dwell_inc;
      end else if (cur_reg != P6 && d_phase == nxt_phase) begin
        cur_reg   <= d_phase;
        dwell_reg <= DWELL_ONE;
        skip_reg  <= 1'b0;
      end else if (d_phase == P6) begin
        saved_reg     <= cur_reg;
        saved_vld_reg <= 1'b1;
        cur_reg       <= P6;
      end else if (cur_reg == P6 && saved_vld_reg && d_phase == saved_reg) begin
        // Returning from an all-red interruption resumes the interrupted count.
        cur_reg       <= d_phase;
        dwell_reg     <= dwell_inc;
        saved_vld_reg <= 1'b0;
      end else if (cur_reg == P6 && !saved_vld_reg) begin
        cur_reg   <= d_phase;
        dwell_reg <= DWELL_ONE;
        skip_reg  <= 1'b1;
      end else begin
        cur_reg       <= d_phase;
        dwell_reg     <= DWELL_ONE;
        skip_reg      <= 1'b1;
        saved_vld_reg <= 1'b0;
      end

      // First cause sticks; a clear in the same cycle as a new fault takes the new cause.
      if (cause != CODE_NONE) begin
        fault_reg <= 1'b1;
        if (!fault_reg || bus.clr)
          code_reg <= cause;
      end else if (bus.clr) begin
        fault_reg <= 1'b0;
        code_reg  <= CODE_NONE;
      end
    end
  end

  assign bus.phase       = cur_reg;
  assign bus.phase_valid = valid_reg;
  assign bus.fault       = fault_reg;
  assign bus.fault_code  = code_reg;
  assign bus.dwell       = dwell_reg;

endmodule
